assertion_scanner: RTL and testbench
====================================

# assertion_scanner

Snapshot engine that sits directly upstream of the assertion region. It drives the region's counter-read handshake (`cnt_req`/`cnt_addr`/`cnt_ack`/`cnt_data`) to sweep all assertion counters into a local snapshot buffer. It also captures the first `assertion_failed` event with a cycle timestamp. The host side reads the frozen snapshot through a simple indexed read port.

## Interface
- `NUM_CNT`, 16: number of counters swept per scan; range 1..64.
- `BASE_ADDR`, 32'h0000_0000: address of counter 0; counter i is at `BASE_ADDR + 4*i`.
- `TIMEOUT`, 255: maximum cycles to wait for `cnt_ack` per request; range 1..65535.

Ports:
- `assert_clk`  in  1  sole clock.
- `assert_rst`  in  1  asynchronous, active-high reset.
- `scan_start`  in  1  one-cycle pulse that requests a full sweep.
- `scan_busy`  out  1  high while a sweep is in progress.
- `scan_done`  out  1  one-cycle pulse when a sweep ends, with or without error.
- `timeout_err`  out  1  sticky; set on any ack timeout; cleared by `scan_start` or reset.
- `cnt_addr`  out  32  counter address, stable while `cnt_req` is high.
- `cnt_req`  out  1  read request to the assertion region.
- `cnt_ack`  in  1  read acknowledge; `cnt_data` is valid in the same cycle.
- `cnt_data`  in  32  counter value.
- `assertion_failed`  in  1  level from the assertion region.
- `fail_seen`  out  1  sticky first-failure flag.
- `fail_time`  out  32  free-running cycle count sampled at the first failure.
- `fail_clr`  in  1  clears `fail_seen` and `fail_time`.
- `rd_idx`  in  6  snapshot index for host reads.
- `rd_data`  out  32  snapshot entry, registered.

## Operation
- FSM states: IDLE, REQ, WAIT, NEXT, DONE.
- IDLE:
  - `scan_start` clears `idx` and `timeout_err`, then moves to REQ.
  - `scan_start` while busy is ignored.
- REQ:
  - Assert `cnt_req` with `cnt_addr = BASE_ADDR + (idx<<2)`; go to WAIT.
- WAIT:
  - Hold `cnt_req` and `cnt_addr` until `cnt_ack` is high.
  - On ack: write `cnt_data` to `snap[idx]`, drop `cnt_req`, go to NEXT.
  - If the wait counter reaches `TIMEOUT`: write 32'hDEAD_BEEF to `snap[idx]`, set `timeout_err`, drop `cnt_req`, go to NEXT.
- NEXT:
  - If `idx == NUM_CNT-1`, go to DONE; otherwise increment `idx` and go to REQ.
  - `cnt_req` is therefore low for at least 1 cycle between requests.
- DONE:
  - Pulse `scan_done` for 1 cycle, then return to IDLE.
- Snapshot buffer:
  - `NUM_CNT` x 32-bit registers.
  - Entries not rewritten by a sweep keep their previous value.
- Host read:
  - `rd_data <= snap[rd_idx]`.
  - If `rd_idx >= NUM_CNT`, `rd_data` reads 0.
- Failure capture:
  - Free-running 32-bit `cycle_cnt` wraps modulo 2^32.
  - On the rising edge of `assertion_failed` with `fail_seen` == 0: set `fail_seen` and latch `fail_time <= cycle_cnt`.
  - Later edges are ignored.
  - If `fail_clr` and a rising edge occur in the same cycle, the edge wins: new capture, flag stays set.

## Timing
- Reset values:
  - All outputs are 0; FSM is in IDLE; `cycle_cnt`, `idx` and snapshot entries are 0.
- Latency:
  - `scan_start` to first `cnt_req`: 2 cycles (IDLE→REQ, REQ drives).
  - A zero-wait ack, where the region acks in the first WAIT cycle, costs 3 cycles per counter (REQ, WAIT, NEXT).
  - Sweep time with zero-wait acks = 3*`NUM_CNT` + 2 cycles from `scan_start` to `scan_done`.
- Timeout:
  - `cnt_req` stays high for exactly `TIMEOUT` WAIT cycles before the abort.
- Host read:
  - `rd_data` has 1-cycle latency.
  - A read of an index written in the same cycle returns the old value.
- Reset mid-sweep:
  - Drops `cnt_req` immediately (asynchronous).
  - No `scan_done` pulse.
- Edge detect:
  - The `assertion_failed` history register resets to 0.
  - An input already high at reset release therefore counts as a rising edge in the first cycle.

## Configuration
- `ASSERT_SCAN_AUTO_EN`:
  - Defined: a new `fail_seen` capture while IDLE triggers a sweep exactly as `scan_start` does, 1 cycle after the capture. A capture while busy does not queue a rescan.
  - Undefined: sweeps start only on `scan_start`.

## Structure
- Package `assertion_pkg`:
  - FSM state enum.
  - `CNT_STRIDE = 4`.
  - `TIMEOUT_FILL = 32'hDEAD_BEEF`.
  - Width constants (32-bit data and address).
- Sub-module `assert_fail_capture`:
  - Contains the edge detect, `cycle_cnt`, `fail_seen`/`fail_time` and clear logic.
  - The top contains the FSM, address generation and snapshot buffer.

## Test plan
- Zero-wait sweep: model acks in the first WAIT cycle with data = 0x100+i and `NUM_CNT`=16 → `scan_done` 50 cycles after `scan_start`; `rd_idx`=5 gives 0x105; `timeout_err`=0.
- Slow ack: ack delayed 7 cycles for i=3 → `cnt_req`/`cnt_addr` (=0x0C) held stable for 7 cycles; `snap[3]` correct.
- Timeout: no ack for i=2 with `TIMEOUT`=10 → `cnt_req` high exactly 10 cycles; `snap[2]`=0xDEADBEEF; `timeout_err`=1; sweep completes.
- Failure capture: `assertion_failed` rises at `cycle_cnt`=1000, then again at 2000 → `fail_time`=1000; `fail_clr` then an edge at 3000 → `fail_time`=3000.
- Reset mid-sweep: assert `assert_rst` while in WAIT → `cnt_req`, `scan_busy`, `fail_seen` low in the same cycle; no `scan_done`; a new `scan_start` after release sweeps normally.
- `ASSERT_SCAN_AUTO_EN` defined: failure edge in IDLE → `cnt_req` 3 cycles after the edge; edge during a sweep → no second sweep.

Source files
------------

// File: rtl/assertion_pkg.sv
// Shared types and constants for the assertion counter scanner.
// Optional build macro: ASSERT_SCAN_AUTO_EN (auto-sweep on first failure).
package assertion_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int IDX_W      = 6;
  localparam int WCNT_W     = 16;
  localparam int CNT_STRIDE = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    NEXT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/assert_fail_capture.sv
// First-failure capture: edge detect, free-running cycle counter,
// sticky flag and timestamp with host clear.
module assert_fail_capture
  import assertion_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              assertion_failed,
  input  logic              fail_clr,
  output logic              fail_seen,
  output logic [DATA_W-1:0] fail_time,
  output logic              cap_pulse
);

  logic              af_q;
  logic [DATA_W-1:0] cycle_cnt;
  logic              rise;
  logic              cap;

  // A rising edge captures when idle or when a clear arrives with it.
  assign rise = assertion_failed & ~af_q;
  assign cap  = rise & (~fail_seen | fail_clr);

  // Edge history, timestamp counter and sticky capture state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q      <= 1'b0;
      cycle_cnt <= '0;
      fail_seen <= 1'b0;
      fail_time <= '0;
      cap_pulse <= 1'b0;
    end else begin
      af_q      <= assertion_failed;
      cycle_cnt <= cycle_cnt + 1'b1;
      cap_pulse <= cap;
      if (cap) begin
        fail_seen <= 1'b1;
        fail_time <= cycle_cnt;
      end else if (fail_clr) begin
        fail_seen <= 1'b0;
        fail_time <= '0;
      end
    end
  end

endmodule

// File: rtl/assertion_scanner.sv
// Sweeps assertion counters into a snapshot buffer via a req/ack
// read port. Optional macro ASSERT_SCAN_AUTO_EN: sweep on new failure.
module assertion_scanner
  import assertion_pkg::*;
#(
  parameter int          NUM_CNT   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        assert_clk,
  input  logic        assert_rst,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        timeout_err,
  output logic [31:0] cnt_addr,
  output logic        cnt_req,
  input  logic        cnt_ack,
  input  logic [31:0] cnt_data,
  input  logic        assertion_failed,
  output logic        fail_seen,
  output logic [31:0] fail_time,
  input  logic        fail_clr,
  input  logic [5:0]  rd_idx,
  output logic [31:0] rd_data
);

  scan_state_e state, state_d;

  logic [IDX_W-1:0]  idx, idx_d;
  logic [WCNT_W-1:0] wcnt, wcnt_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              done_d;
  logic              terr_d;
  logic              snap_we;
  logic [DATA_W-1:0] snap_wdata;
  logic              cap_pulse;
  logic              start_req;

  logic [DATA_W-1:0] snap [NUM_CNT];

  assert_fail_capture u_cap (
    .clk              (assert_clk),
    .rst              (assert_rst),
    .assertion_failed (assertion_failed),
    .fail_clr         (fail_clr),
    .fail_seen        (fail_seen),
    .fail_time        (fail_time),
    .cap_pulse        (cap_pulse)
  );

`ifdef ASSERT_SCAN_AUTO_EN
  assign start_req = scan_start | cap_pulse;
`else
  logic cap_unused;
  assign cap_unused = cap_pulse;
  assign start_req  = scan_start;
`endif

  assign scan_busy = (state != IDLE);

  // FSM state register.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) state <= IDLE;
    else            state <= state_d;
  end

  // Next-state and next-value logic for the sweep.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    wcnt_d     = wcnt;
    req_d      = cnt_req;
    addr_d     = cnt_addr;
    done_d     = 1'b0;
    terr_d     = timeout_err;
    snap_we    = 1'b0;
    snap_wdata = cnt_data;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          idx_d   = '0;
          terr_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d   = 1'b1;
        addr_d  = BASE_ADDR
                + ADDR_W'(idx) * ADDR_W'(CNT_STRIDE);
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_ack) begin
          snap_we    = 1'b1;
          snap_wdata = cnt_data;
          req_d      = 1'b0;
          state_d    = NEXT;
        end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
          snap_we    = 1'b1;
          snap_wdata = TIMEOUT_FILL;
          terr_d     = 1'b1;
          req_d      = 1'b0;
          state_d    = NEXT;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      NEXT: begin
        if (idx == IDX_W'(NUM_CNT - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = REQ;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs, index and wait counter.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      idx         <= '0;
      wcnt        <= '0;
      cnt_req     <= 1'b0;
      cnt_addr    <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      idx         <= idx_d;
      wcnt        <= wcnt_d;
      cnt_req     <= req_d;
      cnt_addr    <= addr_d;
      scan_done   <= done_d;
      timeout_err <= terr_d;
    end
  end

  // Snapshot buffer; untouched entries keep their value.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (snap_we && idx == IDX_W'(i)) snap[i] <= snap_wdata;
      end
    end
  end

  // Registered host read; out-of-range indices return zero.
  always_ff @(posedge assert_clk or posedge assert_rst) begin
    if (assert_rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (rd_idx == IDX_W'(i)) rd_data <= snap[i];
      end
    end
  end

endmodule

// File: tb/tb_assertion_scanner.sv
// Directed bench for assertion_scanner: sweeps, slow ack, timeout,
// failure capture, reset mid-sweep and the auto-sweep option.
module tb_assertion_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_start = 1'b0;
  logic        scan_busy;
  logic        scan_done;
  logic        timeout_err;
  logic [31:0] cnt_addr;
  logic        cnt_req;
  logic        cnt_ack = 1'b0;
  logic [31:0] cnt_data = '0;
  logic        af = 1'b0;
  logic        fail_seen;
  logic [31:0] fail_time;
  logic        fail_clr = 1'b0;
  logic [5:0]  rd_idx = '0;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  int          slow_idx = -1;
  int          noack_idx = -1;
  int          reqcyc = 0;
  logic [31:0] cur_addr = '0;
  int          hold_len [16];
  int          addr_changed = 0;
  int          tcyc = 0;

  assertion_scanner #(
    .NUM_CNT   (16),
    .BASE_ADDR (32'h0000_0000),
    .TIMEOUT   (10)
  ) dut (
    .assert_clk       (clk),
    .assert_rst       (rst),
    .scan_start       (scan_start),
    .scan_busy        (scan_busy),
    .scan_done        (scan_done),
    .timeout_err      (timeout_err),
    .cnt_addr         (cnt_addr),
    .cnt_req          (cnt_req),
    .cnt_ack          (cnt_ack),
    .cnt_data         (cnt_data),
    .assertion_failed (af),
    .fail_seen        (fail_seen),
    .fail_time        (fail_time),
    .fail_clr         (fail_clr),
    .rd_idx           (rd_idx),
    .rd_data          (rd_data)
  );

  always #5 clk = ~clk;

  // Reference cycle counter matching the DUT's free-running count.
  always @(posedge clk or posedge rst) begin
    if (rst) tcyc <= 0;
    else     tcyc <= tcyc + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counter-region model: acks on the Nth request cycle.
  initial begin
    int i;
    int d;
    forever begin
      @(negedge clk);
      if (cnt_req) begin
        if (reqcyc == 0) cur_addr = cnt_addr;
        else if (cnt_addr != cur_addr) addr_changed++;
        reqcyc++;
        i = int'(cur_addr >> 2);
        d = (i == slow_idx) ? 7 : 1;
        if (i != noack_idx && reqcyc == d) begin
          cnt_ack  = 1'b1;
          cnt_data = 32'h100 + 32'(i);
        end else begin
          cnt_ack = 1'b0;
        end
      end else begin
        if (reqcyc > 0 && (cur_addr >> 2) < 16)
          hold_len[int'(cur_addr >> 2)] = reqcyc;
        reqcyc  = 0;
        cnt_ack = 1'b0;
      end
    end
  end

  task automatic run_sweep(output int lat,
                           output logic req1,
                           output logic req2,
                           output logic busy2);
    @(negedge clk);
    scan_start = 1'b1;
    lat = 0;
    req1 = 1'b0;
    req2 = 1'b0;
    busy2 = 1'b0;
    while (lat < 500) begin
      @(negedge clk);
      scan_start = 1'b0;
      lat++;
      if (lat == 1) req1 = cnt_req;
      if (lat == 2) begin
        req2  = cnt_req;
        busy2 = scan_busy;
      end
      if (scan_done) break;
    end
  endtask

  task automatic rd_check(input string tag,
                          input logic [5:0] i,
                          input logic [31:0] exp);
    @(negedge clk);
    rd_idx = i;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   dn;
    logic r1, r2, b2;

    for (int k = 0; k < 16; k++) hold_len[k] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(scan_busy), 0);
    check("rst_done", 32'(scan_done), 0);
    check("rst_terr", 32'(timeout_err), 0);
    check("rst_req", 32'(cnt_req), 0);
    check("rst_addr", cnt_addr, 0);
    check("rst_fseen", 32'(fail_seen), 0);
    check("rst_ftime", fail_time, 0);
    check("rst_rd", rd_data, 0);

    // Zero-wait sweep.
    run_sweep(lat, r1, r2, b2);
    check("zw_lat", 32'(lat), 50);
    check("zw_req_c1", 32'(r1), 0);
    check("zw_req_c2", 32'(r2), 1);
    check("zw_busy", 32'(b2), 1);
    @(negedge clk);
    check("zw_done_pulse", 32'(scan_done), 0);
    check("zw_idle", 32'(scan_busy), 0);
    check("zw_terr", 32'(timeout_err), 0);
    check("zw_hold5", 32'(hold_len[5]), 1);
    rd_check("zw_rd5", 6'd5, 32'h105);
    rd_check("zw_rd0", 6'd0, 32'h100);
    rd_check("zw_rd15", 6'd15, 32'h10F);
    rd_check("zw_rd20", 6'd20, 32'h0);
    rd_check("zw_rd63", 6'd63, 32'h0);

    // Timeout on counter 2.
    noack_idx = 2;
    run_sweep(lat, r1, r2, b2);
    noack_idx = -1;
    check("to_lat", 32'(lat), 59);
    @(negedge clk);
    check("to_hold2", 32'(hold_len[2]), 10);
    check("to_terr", 32'(timeout_err), 1);
    rd_check("to_rd2", 6'd2, 32'hDEAD_BEEF);
    rd_check("to_rd3", 6'd3, 32'h103);

    // Slow ack on counter 3.
    slow_idx = 3;
    addr_changed = 0;
    run_sweep(lat, r1, r2, b2);
    slow_idx = -1;
    check("slow_lat", 32'(lat), 56);
    @(negedge clk);
    check("slow_hold3", 32'(hold_len[3]), 7);
    check("slow_addr_stable", 32'(addr_changed), 0);
    check("slow_terr_clr", 32'(timeout_err), 0);
    rd_check("slow_rd3", 6'd3, 32'h103);
    rd_check("slow_rd2", 6'd2, 32'h102);

    // Failure capture.
    while (tcyc < 1000) @(negedge clk);
    af = 1'b1;
    @(negedge clk);
    check("fc_seen1", 32'(fail_seen), 1);
    check("fc_time1", fail_time, 1000);
    af = 1'b0;
    while (tcyc < 2000) @(negedge clk);
    af = 1'b1;
    @(negedge clk);
    check("fc_time2", fail_time, 1000);
    af = 1'b0;
    repeat (2) @(negedge clk);
    fail_clr = 1'b1;
    @(negedge clk);
    fail_clr = 1'b0;
    check("fc_clr_seen", 32'(fail_seen), 0);
    check("fc_clr_time", fail_time, 0);
    while (tcyc < 3000) @(negedge clk);
    af = 1'b1;
    @(negedge clk);
    check("fc_time3", fail_time, 3000);
    af = 1'b0;
    repeat (80) @(negedge clk);

    // Reset while waiting for an ack.
    noack_idx = 0;
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_req_pre", 32'(cnt_req), 1);
    check("mr_seen_pre", 32'(fail_seen), 1);
    #1 rst = 1'b1;
    #1;
    check("mr_req", 32'(cnt_req), 0);
    check("mr_busy", 32'(scan_busy), 0);
    check("mr_seen", 32'(fail_seen), 0);
    noack_idx = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (scan_done) dn++;
    end
    check("mr_no_done", 32'(dn), 0);
    rd_check("mr_rd4", 6'd4, 32'h0);
    run_sweep(lat, r1, r2, b2);
    check("mr_lat", 32'(lat), 50);
    rd_check("mr_rd0", 6'd0, 32'h100);
    rd_check("mr_rd15", 6'd15, 32'h10F);

`ifdef ASSERT_SCAN_AUTO_EN
    // Auto sweep on a new failure in IDLE.
    @(negedge clk);
    af = 1'b1;
    @(negedge clk);
    af = 1'b0;
    check("au_req_c1", 32'(cnt_req), 0);
    @(negedge clk);
    check("au_req_c2", 32'(cnt_req), 0);
    @(negedge clk);
    check("au_req_c3", 32'(cnt_req), 1);
    @(negedge clk);
    fail_clr = 1'b1;
    af = 1'b1;
    @(negedge clk);
    fail_clr = 1'b0;
    af = 1'b0;
    check("au_seen", 32'(fail_seen), 1);
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (scan_done) dn++;
    end
    check("au_one_sweep", 32'(dn), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
